div_fpu: RTL and testbench

Iterative IEEE-754 single-precision divider (result = a / b). It is the inverse-operation companion to the pipelined FPU multiplier and uses the same start/ready handshake, so the FPU issue logic drives both blocks the same way. It is a multi-cycle, non-pipelined unit with a fixed latency of 27 cycles and one operation in flight at a time. It uses restoring division, one quotient bit per cycle.

---
 rtl/div_fpu.sv | 134 +++++++++++++
 tb/tb_div_fpu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_fpu.sv
// div_fpu: iterative IEEE-754 single-precision divider (result = a / b).
// Restoring division producing one quotient bit per cycle; one operation in
// flight, fixed 27-cycle latency from the accepting edge to the ready pulse.
module div_fpu #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000,
  parameter int          Q_BITS    = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, PACK} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  state_t              state;
  special_t            special;
  logic [4:0]          cnt;
  logic                sign;
  logic [7:0]          exp_a;
  logic [7:0]          exp_b;
  logic [23:0]         mant_a;
  logic [23:0]         mant_b;
  logic [25:0]         rem;
  logic [Q_BITS-1:0]   quo;
  logic                rem_ge;
  logic [24:0]         rem_sub;

  // Special-operand classification, highest priority first. Subnormals
  // (exponent 0) are treated as zero.
  function automatic special_t classify(input logic [31:0] x, input logic [31:0] y);
    logic nan_x, nan_y, inf_x, inf_y, zero_x, zero_y;
    nan_x  = (&x[30:23]) && (|x[22:0]);
    nan_y  = (&y[30:23]) && (|y[22:0]);
    inf_x  = (&x[30:23]) && !(|x[22:0]);
    inf_y  = (&y[30:23]) && !(|y[22:0]);
    zero_x = (x[30:23] == 8'h00);
    zero_y = (y[30:23] == 8'h00);
    if (nan_x || nan_y)        classify = SP_NAN;
    else if (inf_x && inf_y)   classify = SP_NAN;
    else if (zero_x && zero_y) classify = SP_NAN;
    else if (inf_x)            classify = SP_INF;
    else if (zero_y)           classify = SP_INF;
    else if (zero_x)           classify = SP_ZERO;
    else if (inf_y)            classify = SP_ZERO;
    else                       classify = SP_NONE;
  endfunction

  // Normalize the raw quotient, truncate, and saturate the exponent range.
  function automatic logic [31:0] pack_result(input logic s, input special_t sp,
                                              input logic [7:0] ea, input logic [7:0] eb,
                                              input logic [24:0] q);
    logic signed [9:0] e;
    logic [22:0]       m;
    e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + (q[24] ? 10'sd127 : 10'sd126);
    m = q[24] ? q[23:1] : q[22:0];
    case (sp)
      SP_NAN:  pack_result = CANON_NAN;
      SP_INF:  pack_result = {s, 8'hFF, 23'h0};
      SP_ZERO: pack_result = {s, 31'h0};
      default: begin
        if (e >= 10'sd255)     pack_result = {s, 8'hFF, 23'h0};
        else if (e <= 10'sd0)  pack_result = {s, 31'h0};
        else                   pack_result = {s, e[7:0], m};
      end
    endcase
  endfunction

  // Trial subtraction of the divisor from the partial remainder; when the
  // divisor does not fit, the remainder is below 2^24 so bit 25 is zero.
  assign rem_ge  = (rem >= {2'b00, mant_b});
  assign rem_sub = rem_ge ? 25'(rem - {2'b00, mant_b}) : rem[24:0];

  // Control FSM with operand capture, iteration and result packing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      special <= SP_NONE;
      cnt     <= '0;
      sign    <= 1'b0;
      exp_a   <= '0;
      exp_b   <= '0;
      mant_a  <= '0;
      mant_b  <= '0;
      rem     <= '0;
      quo     <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      result  <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CALC;
            cnt     <= '0;
            sign    <= a[31] ^ b[31];
            exp_a   <= a[30:23];
            exp_b   <= b[30:23];
            mant_a  <= {1'b1, a[22:0]};
            mant_b  <= {1'b1, b[22:0]};
            special <= classify(a, b);
          end
        end
        CALC: begin
          busy <= 1'b1;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd0) begin
            // Unpack cycle: seed the remainder with the dividend mantissa.
            rem <= {2'b00, mant_a};
            quo <= '0;
          end else begin
            rem <= {rem_sub, 1'b0};
            quo <= {quo[Q_BITS-2:0], rem_ge};
          end
          if (cnt == 5'(Q_BITS)) state <= PACK;
        end
        PACK: begin
          busy   <= 1'b0;
          ready  <= 1'b1;
          result <= pack_result(sign, special, exp_a, exp_b, quo);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_fpu.sv
// tb_div_fpu: table-driven directed vectors, handshake/reset sequences and
// randomized operands checked against a behavioural division model.
module tb_div_fpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        ready;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  div_fpu dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .ready  (ready),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer ratio of the mantissas, then the IEEE rules.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    int     ex = int'(x[30:23]);
    int     ey = int'(y[30:23]);
    int     e;
    bit     s  = x[31] ^ y[31];
    bit     nx = (ex == 255) && (x[22:0] != 0);
    bit     ny = (ey == 255) && (y[22:0] != 0);
    bit     ix = (ex == 255) && (x[22:0] == 0);
    bit     iy = (ey == 255) && (y[22:0] == 0);
    bit     zx = (ex == 0);
    bit     zy = (ey == 0);
    longint q;
    if (nx || ny) return 32'h7FC00000;
    if (ix && iy) return 32'h7FC00000;
    if (zx && zy) return 32'h7FC00000;
    if (ix || zy) return {s, 8'hFF, 23'h0};
    if (zx || iy) return {s, 31'h0};
    q = ((longint'(x[22:0]) + 64'h800000) << 24) / (longint'(y[22:0]) + 64'h800000);
    if (q >= 64'h1000000) begin
      e = ex - ey + 127;
      q = q >> 1;
    end else begin
      e = ex - ey + 126;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          sel;
    v   = $urandom;
    sel = $urandom_range(0, 11);
    case (sel)
      0: v[30:0] = '0;
      1: v[30:0] = {8'hFF, 23'h0};
      2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      3: v[30:23] = 8'h00;
      4: v[30:23] = 8'($urandom_range(230, 254));
      5: v[30:23] = 8'($urandom_range(1, 25));
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // From just before the accepting edge: wait for the result, optionally
  // poking start with other operands after edge N+poke_k.
  task automatic wait_res(input int poke_k, input logic [31:0] pa, input logic [31:0] pb,
                          output logic [31:0] res, output int lat, output int bcnt);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    lat  = -1;
    bcnt = 0;
    res  = '0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) bcnt++;
      if (ready) begin
        lat = k;
        res = result;
      end
      if (k == poke_k) begin
        start = 1'b1;
        a = pa;
        b = pb;
      end else if (k == poke_k + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input int poke_k,
                       input logic [31:0] pa, input logic [31:0] pb,
                       output logic [31:0] res, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb;
    wait_res(poke_k, pa, pb, res, lat, bcnt);
  endtask

  initial begin
    vec_t        vecs[13];
    logic [31:0] res;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;
    int          bcnt;
    int          pulses;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA};
    vecs[2]  = '{32'hC0000000, 32'h3F000000, 32'hC0800000};
    vecs[3]  = '{32'hBF800000, 32'h00000000, 32'hFF800000};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000};
    vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    vecs[6]  = '{32'h00000000, 32'hC0000000, 32'h80000000};
    vecs[7]  = '{32'h7F000000, 32'h00800000, 32'h7F800000};
    vecs[8]  = '{32'h00800000, 32'h7F000000, 32'h00000000};
    vecs[9]  = '{32'h00400000, 32'h3F800000, 32'h00000000};
    vecs[10] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000};
    vecs[11] = '{32'h7F800000, 32'hC0000000, 32'hFF800000};
    vecs[12] = '{32'h40400000, 32'h7F800000, 32'h00000000};

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset ready", {31'b0, ready}, 32'd0);
    check("reset result", result, 32'h0);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].a, vecs[i].b, 0, '0, '0, res, lat, bcnt);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), lat, 27);
      check($sformatf("vec%0d busy cycles", i), bcnt, 26);
    end

    // start while busy is ignored, and nothing is queued behind it
    do_op(32'h40C00000, 32'h40000000, 4, 32'h3F800000, 32'h40400000, res, lat, bcnt);
    check("poke result", res, 32'h40400000);
    check("poke latency", lat, 27);
    check("poke busy cycles", bcnt, 26);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("poke no extra ready", pulses, 0);

    // start during the ready cycle is accepted
    do_op(32'h40C00000, 32'h40000000, 0, '0, '0, res, lat, bcnt);
    check("b2b first result", res, 32'h40400000);
    check("b2b ready now", {31'b0, ready}, 32'd1);
    start = 1'b1;
    a = 32'h3F800000;
    b = 32'h40400000;
    wait_res(0, '0, '0, res, lat, bcnt);
    check("b2b second result", res, 32'h3EAAAAAA);
    check("b2b second latency", lat, 27);

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1;
    a = 32'h40C00000;
    b = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst ready", {31'b0, ready}, 32'd0);
    check("midrst result", result, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("midrst no ready", pulses, 0);
    do_op(32'h40C00000, 32'h40000000, 0, '0, '0, res, lat, bcnt);
    check("post-rst result", res, 32'h40400000);
    check("post-rst latency", lat, 27);

    // Randomized operands against the model
    for (int i = 0; i < 40; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      do_op(ra, rb, 0, '0, '0, res, lat, bcnt);
      check($sformatf("rand%0d %h/%h", i, ra, rb), res, model(ra, rb));
      check($sformatf("rand%0d latency", i), lat, 27);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
